// File: rtl/mem_access_initiator.sv
// Load/store initiator for a dword-wide data memory: one request at a time,
// sub-dword stores performed as read-modify-write on the containing dword.
module mem_access_initiator #(
   parameter int unsigned MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_error,
   output logic [63:0] Mem_Addr,
   output logic [63:0] Write_Data,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [63:0] Read_Data
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      MERGE = 3'd2,
      WR    = 3'd3,
      RESP  = 3'd4
   } state_e;

   state_e      state_q;
   logic        write_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [2:0]  off_q;
   logic [63:0] wdata_q;
   logic [63:0] old_q;
   logic [63:0] mem_addr_q;
   logic [63:0] write_data_q;
   logic [63:0] rsp_rdata_q;
   logic        rsp_error_q;

   logic        req_fire;
   logic        misalign;
   logic        out_of_range;
   logic        req_err;
   logic [63:0] lane;
   logic [63:0] rdata_d;
   logic [63:0] size_mask;
   logic [63:0] byte_mask;
   logic [63:0] merge_d;

   assign req_ready = reset_n && (state_q == IDLE);
   assign req_fire  = req_valid && req_ready;

   always_comb begin
      misalign = 1'b0;
      case (req_size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = req_addr[0];
         2'd2:    misalign = |req_addr[1:0];
         default: misalign = |req_addr[2:0];
      endcase
   end

   assign out_of_range = (req_addr >= 64'(MEM_BYTES));
   assign req_err      = misalign || out_of_range;

   // Load path: right-justify the addressed lane, then extend per size/sign.
   always_comb begin
      lane    = Read_Data >> {off_q, 3'b000};
      rdata_d = '0;
      case (size_q)
         2'd0:    rdata_d = unsigned_q ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
         2'd1:    rdata_d = unsigned_q ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
         2'd2:    rdata_d = unsigned_q ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
         default: rdata_d = lane;
      endcase
   end

   // Store path: replace only the addressed bytes of the previously read dword.
   always_comb begin
      size_mask = '0;
      case (size_q)
         2'd0:    size_mask = 64'h0000_0000_0000_00FF;
         2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = '1;
      endcase
      byte_mask = size_mask << {off_q, 3'b000};
      merge_d   = (old_q & ~byte_mask) | ((wdata_q << {off_q, 3'b000}) & byte_mask);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         size_q       <= 2'd0;
         unsigned_q   <= 1'b0;
         off_q        <= 3'd0;
         wdata_q      <= '0;
         old_q        <= '0;
         mem_addr_q   <= '0;
         write_data_q <= '0;
         rsp_rdata_q  <= '0;
         rsp_error_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_fire) begin
                  write_q     <= req_write;
                  size_q      <= req_size;
                  unsigned_q  <= req_unsigned;
                  off_q       <= req_addr[2:0];
                  wdata_q     <= req_wdata;
                  mem_addr_q  <= {req_addr[63:3], 3'b000};
                  rsp_rdata_q <= '0;
                  rsp_error_q <= req_err;
                  if (req_err) begin
                     state_q <= RESP;
                  end else if (req_write && (req_size == 2'd3)) begin
                     write_data_q <= req_wdata;
                     state_q      <= WR;
                  end else begin
                     state_q <= RD;
                  end
               end
            end
            RD: begin
               if (write_q) begin
                  old_q   <= Read_Data;
                  state_q <= MERGE;
               end else begin
                  rsp_rdata_q <= rdata_d;
                  state_q     <= RESP;
               end
            end
            MERGE: begin
               write_data_q <= merge_d;
               state_q      <= WR;
            end
            WR: begin
               state_q <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Strobes decode straight from the state register so reset removes them asynchronously.
   assign MemRead    = (state_q == RD);
   assign MemWrite   = (state_q == WR);
   assign rsp_valid  = (state_q == RESP);
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_error  = rsp_error_q;
   assign Mem_Addr   = mem_addr_q;
   assign Write_Data = write_data_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator with an 8-dword behavioural data memory.
module tb_mem_access_initiator;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_error;
   logic [63:0] Mem_Addr;
   logic [63:0] Write_Data;
   logic        MemWrite;
   logic        MemRead;
   logic [63:0] Read_Data;

   logic [63:0] mem [8];
   logic        pl_en;
   logic [2:0]  pl_idx;
   logic [63:0] pl_data;

   int errors = 0;
   int checks = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   logic both_seen = 1'b0;

   mem_access_initiator #(.MEM_BYTES(64)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_error    (rsp_error),
      .Mem_Addr     (Mem_Addr),
      .Write_Data   (Write_Data),
      .MemWrite     (MemWrite),
      .MemRead      (MemRead),
      .Read_Data    (Read_Data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign Read_Data = mem[Mem_Addr[5:3]];

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (MemWrite) mem[Mem_Addr[5:3]] <= Write_Data;
   end

   always @(posedge clk) begin
      if (MemRead) rd_cnt++;
      if (MemWrite) wr_cnt++;
      if (MemRead && MemWrite) both_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [2:0] idx, input logic [63:0] data);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // One transaction; hold = cycles rsp_ready stays low once rsp_valid is seen.
   // Latency is counted in negedges after the accept edge (spec latency minus one).
   task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd, input int hold,
                       input int exp_lat, input logic [63:0] exp_rdata, input logic exp_err,
                       input int exp_rd, input int exp_wr);
      int rd0, wr0, lat;
      logic [63:0] got_rdata;
      logic        got_err;
      @(negedge clk);
      req_write = w; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      chk({tag, "_ready"}, 64'(req_ready), 64'd1);
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_addr = 64'hDEAD_BEEF_0000_0000;
      lat = 0;
      @(negedge clk);
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < hold; i++) begin
         chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
         chk({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
         chk({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
         chk({tag, "_hold_strobe"}, 64'(MemRead | MemWrite), 64'd0);
         @(negedge clk);
      end
      got_rdata = rsp_rdata;
      got_err   = rsp_error;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_rdata"}, got_rdata, exp_rdata);
      chk({tag, "_err"}, 64'(got_err), 64'(exp_err));
      chk({tag, "_nrd"}, 64'(rd_cnt - rd0), 64'(exp_rd));
      chk({tag, "_nwr"}, 64'(wr_cnt - wr0), 64'(exp_wr));
      chk({tag, "_done"}, 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      int wr_snap;
      reset_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      pl_en = 1'b0; pl_idx = '0; pl_data = '0;

      for (int i = 0; i < 8; i++) preload(3'(i), 64'd0);
      preload(3'd1, 64'd2);
      preload(3'd2, 64'h01);
      preload(3'd5, 64'hA5A5_5A5A_1234_5678);

      #1;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_err", 64'(rsp_error), 64'd0);
      chk("rst_rd", 64'(MemRead), 64'd0);
      chk("rst_wr", 64'(MemWrite), 64'd0);
      chk("rst_addr", Mem_Addr, 64'd0);
      chk("rst_wdata", Write_Data, 64'd0);
      chk("rst_rdata", rsp_rdata, 64'd0);

      @(negedge clk);
      reset_n = 1'b1;

      xact("ld8", 1'b0, 2'd3, 1'b0, 64'd8, 64'd0, 0, 1, 64'd2, 1'b0, 1, 0);
      xact("sb17", 1'b1, 2'd0, 1'b0, 64'd17, 64'hFF, 0, 3, 64'd0, 1'b0, 1, 1);
      chk("mem16", mem[2], 64'h0000_0000_0000_FF01);
      xact("lbs17", 1'b0, 2'd0, 1'b0, 64'd17, 64'd0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 0);
      xact("lbu17", 1'b0, 2'd0, 1'b1, 64'd17, 64'd0, 0, 1, 64'h0000_0000_0000_00FF, 1'b0, 1, 0);
      xact("lw2", 1'b0, 2'd2, 1'b0, 64'd2, 64'd0, 0, 0, 64'd0, 1'b1, 0, 0);
      xact("ld64", 1'b0, 2'd3, 1'b0, 64'd64, 64'd0, 0, 0, 64'd0, 1'b1, 0, 0);
      xact("sw_err", 1'b1, 2'd1, 1'b0, 64'd9, 64'h1234, 0, 0, 64'd0, 1'b1, 0, 0);
      xact("hold", 1'b0, 2'd3, 1'b0, 64'd8, 64'd0, 3, 1, 64'd2, 1'b0, 1, 0);

      // Reset while a half store to 40 is in RD.
      @(negedge clk);
      req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 64'd40;
      req_wdata = 64'hBEEF; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("abort_inrd", 64'(MemRead), 64'd1);
      wr_snap = wr_cnt;
      #2 reset_n = 1'b0;
      #1;
      chk("abort_rd_low", 64'(MemRead), 64'd0);
      chk("abort_wr_low", 64'(MemWrite), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("abort_ready", 64'(req_ready), 64'd1);
      chk("abort_nwr", 64'(wr_cnt - wr_snap), 64'd0);
      chk("abort_mem40", mem[5], 64'hA5A5_5A5A_1234_5678);

      xact("sd0", 1'b1, 2'd3, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 0, 1, 64'd0, 1'b0, 0, 1);
      xact("ld0", 1'b0, 2'd3, 1'b0, 64'd0, 64'd0, 0, 1, 64'h1122_3344_5566_7788, 1'b0, 1, 0);
      xact("sh44", 1'b1, 2'd1, 1'b0, 64'd44, 64'hFFFF_BEEF, 0, 3, 64'd0, 1'b0, 1, 1);
      chk("mem40", mem[5], 64'hA5A5_BEEF_1234_5678);
      xact("lws44", 1'b0, 2'd2, 1'b0, 64'd44, 64'd0, 0, 1, 64'hFFFF_FFFF_A5A5_BEEF, 1'b0, 1, 0);
      xact("lhu46", 1'b0, 2'd1, 1'b1, 64'd46, 64'd0, 0, 1, 64'h0000_0000_0000_A5A5, 1'b0, 1, 0);
      xact("sw52", 1'b1, 2'd2, 1'b0, 64'd52, 64'h8000_0001, 0, 3, 64'd0, 1'b0, 1, 1);
      chk("mem48", mem[6], 64'h8000_0001_0000_0000);
      xact("lws52", 1'b0, 2'd2, 1'b0, 64'd52, 64'd0, 0, 1, 64'hFFFF_FFFF_8000_0001, 1'b0, 1, 0);
      xact("lhs48", 1'b0, 2'd1, 1'b0, 64'd48, 64'd0, 0, 1, 64'd0, 1'b0, 1, 0);

      chk("strobe_excl", 64'(both_seen), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
